edge_pass_scheduler: RTL and testbench

// - Sequences one Sobel edge-detection pass per accepted camera frame; owns the mux of the frame-buffer read port and the edge BRAM port.
// - Sits between camera frame-done, the sobel engine, video_playback and the two BRAMs, replacing the fixed done-based port select.
// - Passes start only in VGA vertical blank, so the display never reads a half-written edge map.

---
 rtl/edge_sched_pkg.sv | 20 ++
 rtl/edge_port_mux.sv | 38 +++
 rtl/edge_pass_scheduler.sv | 162 ++++++++++++++++
 tb/tb_edge_pass_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_sched_pkg.sv
// Shared scheduler state type and VGA frame geometry for the edge-pass scheduler slice.
package edge_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } sched_state_t;

  localparam int VGA_W       = 640;
  localparam int VGA_H       = 480;
  localparam int FRAME_WORDS = VGA_W * VGA_H;

  // The Sobel path owns both BRAM ports whenever a pass is in flight.
  function automatic logic sobel_owns_ports(input sched_state_t state);
    return state != IDLE;
  endfunction

endpackage

// File: rtl/edge_port_mux.sv
// Combinational BRAM port select: VGA display when idle, Sobel engine while a pass is in flight.
module edge_port_mux
  import edge_sched_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int EDGE_W = 3
) (
  input  sched_state_t      i_state,
  input  logic [ADDR_W-1:0] i_vga_addr,
  input  logic [ADDR_W-1:0] i_sobel_rgb_addr,
  input  logic [ADDR_W-1:0] i_sobel_edge_addr,
  input  logic [EDGE_W-1:0] i_sobel_edge_din,
  input  logic              i_sobel_edge_we,
  output logic [ADDR_W-1:0] o_fb_rd_addr,
  output logic [ADDR_W-1:0] o_edge_addr,
  output logic [EDGE_W-1:0] o_edge_din,
  output logic              o_edge_we
);

  logic w_sobel_sel;

  assign w_sobel_sel = sobel_owns_ports(i_state);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    o_fb_rd_addr = i_vga_addr;
    o_edge_addr  = i_vga_addr;
    o_edge_din   = '0;
    o_edge_we    = 1'b0;
    if (w_sobel_sel) begin
      o_fb_rd_addr = i_sobel_rgb_addr;
      o_edge_addr  = i_sobel_edge_addr;
      o_edge_din   = i_sobel_edge_din;
      o_edge_we    = i_sobel_edge_we;
    end
  end

endmodule

// File: rtl/edge_pass_scheduler.sv
// Runs one Sobel pass per accepted camera frame, launched only in VGA vertical blank.
// Optional RUN-phase watchdog is compiled in with `define EDGE_SCHED_WATCHDOG_EN.
module edge_pass_scheduler
  import edge_sched_pkg::*;
#(
  parameter int ADDR_W    = 19,
  parameter int EDGE_W    = 3,
  parameter int PASS_DIV  = 1,
  parameter int FLUSH_CYC = 4,
  parameter int WD_CYC    = 400000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_valid,
  input  logic              vga_vblank,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic [ADDR_W-1:0] sobel_rgb_addr,
  input  logic [ADDR_W-1:0] sobel_edge_addr,
  input  logic [EDGE_W-1:0] sobel_edge_din,
  input  logic              sobel_edge_we,
  input  logic              sobel_done,
  output logic              sobel_start,
  output logic              sobel_abort,
  output logic [ADDR_W-1:0] fb_rd_addr,
  output logic [ADDR_W-1:0] edge_addr,
  output logic [EDGE_W-1:0] edge_din,
  output logic              edge_we,
  output logic              busy,
  output logic [15:0]       pass_count,
  output logic [7:0]        drop_count,
  output logic              wd_error
);

  localparam logic [3:0]         DIV_LAST   = 4'(PASS_DIV - 1);
  localparam int                 FLUSH_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);

  sched_state_t       r_state;
  sched_state_t       w_next_state;
  logic [3:0]         r_div_cnt;
  logic               r_pending;
  logic               r_run_first;
  logic [FLUSH_W-1:0] r_flush_cnt;
  logic [15:0]        r_pass_cnt;
  logic [7:0]         r_drop_cnt;

  logic w_accept;
  logic w_arm_take;
  logic w_done_seen;
  logic w_flush_end;
  logic w_wd_abort;
  logic w_pass_done;

  assign w_accept    = frame_valid && (r_div_cnt == DIV_LAST);
  assign w_arm_take  = (r_state == IDLE) && r_pending && vga_vblank;
  // The engine still reports done during its first RUN cycle, so that cycle is ignored.
  assign w_done_seen = (r_state == RUN) && !r_run_first && sobel_done;
  assign w_flush_end = (r_state == FLUSH) && (r_flush_cnt == FLUSH_LAST);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_arm_take) w_next_state = ARM;
      ARM:     w_next_state = RUN;
      RUN:     if (w_done_seen || w_wd_abort) w_next_state = FLUSH;
      FLUSH:   if (w_flush_end) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    sobel_start = (r_state == ARM);
    sobel_abort = w_wd_abort;
    busy        = sobel_owns_ports(r_state);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt   <= '0;
      r_pending   <= 1'b0;
      r_run_first <= 1'b0;
      r_flush_cnt <= '0;
      r_pass_cnt  <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (frame_valid) r_div_cnt <= (r_div_cnt == DIV_LAST) ? 4'd0 : r_div_cnt + 4'd1;
      // A new accept beats the ARM-time clear; it only counts as a drop if the old request survives.
      if (w_accept) begin
        r_pending <= 1'b1;
        if (r_pending && !w_arm_take && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      end else if (w_arm_take) begin
        r_pending <= 1'b0;
      end
      r_run_first <= (r_state == ARM);
      r_flush_cnt <= (r_state == FLUSH) ? r_flush_cnt + 1'b1 : '0;
      if (w_pass_done) r_pass_cnt <= r_pass_cnt + 16'd1;
    end
  end

`ifdef EDGE_SCHED_WATCHDOG_EN
  localparam int               RUN_W    = (WD_CYC > 1) ? $clog2(WD_CYC) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(WD_CYC - 1);

  logic [RUN_W-1:0] r_run_cnt;
  logic             r_aborted;
  logic             r_wd_error;

  // Completion on the watchdog's last cycle still counts as a normal pass.
  assign w_wd_abort  = (r_state == RUN) && !w_done_seen && (r_run_cnt == RUN_LAST);
  assign w_pass_done = w_flush_end && !r_aborted;
  assign wd_error    = r_wd_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_cnt  <= '0;
      r_aborted  <= 1'b0;
      r_wd_error <= 1'b0;
    end else begin
      r_run_cnt <= (r_state == RUN) ? r_run_cnt + 1'b1 : '0;
      if (w_wd_abort) begin
        r_aborted  <= 1'b1;
        r_wd_error <= 1'b1;
      end else if (w_flush_end) begin
        r_aborted  <= 1'b0;
      end
    end
  end
`else
  logic w_unused_wd_cyc;

  assign w_unused_wd_cyc = ^WD_CYC;
  assign w_wd_abort      = 1'b0;
  assign w_pass_done     = w_flush_end;
  assign wd_error        = 1'b0;
`endif

  assign pass_count = r_pass_cnt;
  assign drop_count = r_drop_cnt;

  edge_port_mux #(
    .ADDR_W (ADDR_W),
    .EDGE_W (EDGE_W)
  ) u_port_mux (
    .i_state           (r_state),
    .i_vga_addr        (vga_addr),
    .i_sobel_rgb_addr  (sobel_rgb_addr),
    .i_sobel_edge_addr (sobel_edge_addr),
    .i_sobel_edge_din  (sobel_edge_din),
    .i_sobel_edge_we   (sobel_edge_we),
    .o_fb_rd_addr      (fb_rd_addr),
    .o_edge_addr       (edge_addr),
    .o_edge_din        (edge_din),
    .o_edge_we         (edge_we)
  );

endmodule

// File: tb/tb_edge_pass_scheduler.sv
// Self-checking bench for edge_pass_scheduler: directed scenarios plus a randomized run against a pass-level model.
module tb_edge_pass_scheduler;

  localparam int TB_DIV   = 1;
  localparam int TB_FLUSH = 4;
  localparam int TB_WD    = 5000;
`ifdef EDGE_SCHED_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, frame_valid, vga_vblank, sobel_edge_we, sobel_done;
  logic [18:0] vga_addr, sobel_rgb_addr, sobel_edge_addr;
  logic [2:0]  sobel_edge_din;

  logic        start1, abort1, ewe1, busy1, wderr1;
  logic [18:0] fb1, eaddr1;
  logic [2:0]  edin1;
  logic [15:0] pass1;
  logic [7:0]  drop1;
  logic        start3, abort3, ewe3, busy3, wderr3;
  logic [18:0] fb3, eaddr3;
  logic [2:0]  edin3;
  logic [15:0] pass3;
  logic [7:0]  drop3;

  int errors = 0;
  int checks = 0;

  // Pass-level reference model for dut1: age counts cycles since ARM, drain counts remaining flush cycles.
  int m_div, m_age, m_drain, m_pass, m_drop;
  bit m_pending, m_active, m_abort_pass, m_wd_err;

  always #5 clk = ~clk;

  edge_pass_scheduler #(.ADDR_W(19), .EDGE_W(3), .PASS_DIV(TB_DIV), .FLUSH_CYC(TB_FLUSH), .WD_CYC(TB_WD)) dut1 (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .vga_vblank(vga_vblank), .vga_addr(vga_addr),
    .sobel_rgb_addr(sobel_rgb_addr), .sobel_edge_addr(sobel_edge_addr), .sobel_edge_din(sobel_edge_din),
    .sobel_edge_we(sobel_edge_we), .sobel_done(sobel_done), .sobel_start(start1), .sobel_abort(abort1),
    .fb_rd_addr(fb1), .edge_addr(eaddr1), .edge_din(edin1), .edge_we(ewe1), .busy(busy1),
    .pass_count(pass1), .drop_count(drop1), .wd_error(wderr1));

  edge_pass_scheduler #(.ADDR_W(19), .EDGE_W(3), .PASS_DIV(3), .FLUSH_CYC(TB_FLUSH), .WD_CYC(100)) dut3 (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .vga_vblank(vga_vblank), .vga_addr(vga_addr),
    .sobel_rgb_addr(sobel_rgb_addr), .sobel_edge_addr(sobel_edge_addr), .sobel_edge_din(sobel_edge_din),
    .sobel_edge_we(sobel_edge_we), .sobel_done(sobel_done), .sobel_start(start3), .sobel_abort(abort3),
    .fb_rd_addr(fb3), .edge_addr(eaddr3), .edge_din(edin3), .edge_we(ewe3), .busy(busy3),
    .pass_count(pass3), .drop_count(drop3), .wd_error(wderr3));

  function automatic void model_update();
    bit accept, start_now, fin, wd;
    if (reset) begin
      m_div = 0; m_age = 0; m_drain = 0; m_pass = 0; m_drop = 0;
      m_pending = 0; m_active = 0; m_abort_pass = 0; m_wd_err = 0;
      return;
    end
    accept    = frame_valid && (m_div == TB_DIV - 1);
    start_now = !m_active && m_pending && vga_vblank;
    if (frame_valid) m_div = accept ? 0 : m_div + 1;
    if (accept) begin
      if (m_pending && !start_now && m_drop < 255) m_drop++;
      m_pending = 1;
    end else if (start_now) begin
      m_pending = 0;
    end
    if (!m_active) begin
      if (start_now) begin m_active = 1; m_age = 0; m_drain = 0; end
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) begin
        m_active = 0;
        if (!m_abort_pass) m_pass = (m_pass + 1) % 65536;
        m_abort_pass = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else begin
      fin = (m_age >= 2) && sobel_done;
      wd  = WD_EN && !fin && (m_age == TB_WD);
      if (fin || wd) begin
        m_drain = TB_FLUSH;
        if (wd) begin m_abort_pass = 1; m_wd_err = 1; end
      end else begin
        m_age++;
      end
    end
  endfunction

  // One clock: model follows the edge, then fresh random datapath inputs are applied.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    vga_addr        = 19'($urandom);
    sobel_rgb_addr  = ~vga_addr;
    sobel_edge_addr = vga_addr ^ (19'($urandom) | 19'd1);
    sobel_edge_din  = 3'($urandom);
    sobel_edge_we   = 1'($urandom);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_valid = 1'b0; vga_vblank = 1'b0; sobel_done = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    sobel_edge_we = 1'b1; sobel_edge_din = 3'd7; #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
    checks++; if (start1 !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", start1); end
    checks++; if (abort1 !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b want 0", abort1); end
    checks++; if (ewe1 !== 1'b0 || edin1 !== 3'd0) begin errors++; $display("FAIL reset_edge_we: got we=%b din=%0d want 0/0", ewe1, edin1); end
    checks++; if (pass1 !== 16'd0 || drop1 !== 8'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", pass1, drop1); end
    checks++; if (wderr1 !== 1'b0) begin errors++; $display("FAIL reset_wd_error: got %b want 0", wderr1); end
    checks++; if (fb1 !== vga_addr || eaddr1 !== vga_addr) begin errors++; $display("FAIL reset_ports: got %h/%h want %h", fb1, eaddr1, vga_addr); end
  endtask

  task automatic test_single_pass();
    do_reset();
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    repeat (199) tick();
    vga_vblank = 1'b1;
    checks++; if (start1 !== 1'b0 || fb1 !== vga_addr) begin errors++; $display("FAIL pre_vblank: got start=%b fb=%h want 0/%h", start1, fb1, vga_addr); end
    tick();
    checks++; if (start1 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL start_after_vblank: got start=%b busy=%b want 1/1", start1, busy1); end
    checks++; if (fb1 !== sobel_rgb_addr || eaddr1 !== sobel_edge_addr || edin1 !== sobel_edge_din || ewe1 !== sobel_edge_we) begin
      errors++; $display("FAIL arm_ports: got fb=%h ea=%h want %h/%h", fb1, eaddr1, sobel_rgb_addr, sobel_edge_addr); end
    tick();
    checks++; if (start1 !== 1'b0) begin errors++; $display("FAIL start_width: got %b want 0", start1); end
    tick();
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL first_run_done_ignored: got busy=%b want 1", busy1); end
    vga_vblank = 1'b0; sobel_done = 1'b0;
    repeat (998) tick();
    checks++; if (busy1 !== 1'b1 || fb1 !== sobel_rgb_addr) begin errors++; $display("FAIL vblank_drop_keeps_pass: got busy=%b fb=%h want 1/%h", busy1, fb1, sobel_rgb_addr); end
    sobel_done = 1'b1;
    repeat (4) tick();
    checks++; if (busy1 !== 1'b1 || pass1 !== 16'd0) begin errors++; $display("FAIL flush_hold: got busy=%b pass=%0d want 1/0", busy1, pass1); end
    tick();
    checks++; if (busy1 !== 1'b0 || fb1 !== vga_addr || eaddr1 !== vga_addr) begin errors++; $display("FAIL flush_release: got busy=%b fb=%h want 0/%h", busy1, fb1, vga_addr); end
    checks++; if (pass1 !== 16'd1 || ewe1 !== 1'b0 || edin1 !== 3'd0) begin errors++; $display("FAIL pass_done: got pass=%0d we=%b din=%0d want 1/0/0", pass1, ewe1, edin1); end
  endtask

  task automatic test_drop();
    do_reset();
    repeat (3) begin frame_valid = 1'b1; tick(); frame_valid = 1'b0; repeat (5) tick(); end
    vga_vblank = 1'b1; repeat (20) tick(); vga_vblank = 1'b0; tick();
    checks++; if (pass1 !== 16'd1 || drop1 !== 8'd2) begin errors++; $display("FAIL drop_three_frames: got pass=%0d drop=%0d want 1/2", pass1, drop1); end
  endtask

  task automatic test_pass_div3();
    do_reset();
    repeat (6) begin
      frame_valid = 1'b1; tick(); frame_valid = 1'b0;
      repeat (5) tick();
      vga_vblank = 1'b1; repeat (15) tick(); vga_vblank = 1'b0; repeat (3) tick();
    end
    checks++; if (pass3 !== 16'd2 || drop3 !== 8'd0) begin errors++; $display("FAIL div3_passes: got pass=%0d drop=%0d want 2/0", pass3, drop3); end
    checks++; if (pass1 !== 16'd6 || drop1 !== 8'd0) begin errors++; $display("FAIL div1_passes: got pass=%0d drop=%0d want 6/0", pass1, drop1); end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    repeat (300) begin frame_valid = 1'b1; tick(); frame_valid = 1'b0; tick(); end
    checks++; if (drop1 !== 8'd255 || busy1 !== 1'b0) begin errors++; $display("FAIL drop_saturate: got drop=%0d busy=%b want 255/0", drop1, busy1); end
    checks++; if (drop3 !== 8'd99) begin errors++; $display("FAIL div3_drop: got %0d want 99", drop3); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    vga_vblank = 1'b1;
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    repeat (10) tick();
    checks++; if (pass1 !== 16'd1 || busy1 !== 1'b0) begin errors++; $display("FAIL prerun_pass: got pass=%0d busy=%b want 1/0", pass1, busy1); end
    sobel_done = 1'b0;
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    tick(); tick();
    frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    repeat (5) tick();
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL mid_run_busy: got %b want 1", busy1); end
    reset = 1'b1; tick();
    checks++; if (busy1 !== 1'b0 || start1 !== 1'b0) begin errors++; $display("FAIL reset_mid_run_state: got busy=%b start=%b want 0/0", busy1, start1); end
    checks++; if (pass1 !== 16'd0 || drop1 !== 8'd0) begin errors++; $display("FAIL reset_mid_run_counts: got %0d/%0d want 0/0", pass1, drop1); end
    checks++; if (fb1 !== vga_addr) begin errors++; $display("FAIL reset_mid_run_ports: got %h want %h", fb1, vga_addr); end
    reset = 1'b0; sobel_done = 1'b1;
    repeat (10) tick();
    checks++; if (busy1 !== 1'b0 || pass1 !== 16'd0) begin errors++; $display("FAIL pending_lost: got busy=%b pass=%0d want 0/0", busy1, pass1); end
  endtask

`ifdef EDGE_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    sobel_done = 1'b0;
    repeat (3) begin frame_valid = 1'b1; tick(); frame_valid = 1'b0; tick(); end
    vga_vblank = 1'b1; tick();
    checks++; if (start3 !== 1'b1) begin errors++; $display("FAIL wd_start: got %b want 1", start3); end
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (n == 99) begin checks++; if (abort3 !== 1'b0) begin errors++; $display("FAIL wd_early: got %b want 0", abort3); end end
    end
    checks++; if (abort3 !== 1'b1 || busy3 !== 1'b1) begin errors++; $display("FAIL wd_abort: got abort=%b busy=%b want 1/1", abort3, busy3); end
    tick();
    checks++; if (abort3 !== 1'b0 || wderr3 !== 1'b1 || busy3 !== 1'b1) begin errors++; $display("FAIL wd_flush: got abort=%b err=%b busy=%b want 0/1/1", abort3, wderr3, busy3); end
    repeat (4) tick();
    checks++; if (busy3 !== 1'b0 || pass3 !== 16'd0 || wderr3 !== 1'b1) begin errors++; $display("FAIL wd_idle: got busy=%b pass=%0d err=%b want 0/0/1", busy3, pass3, wderr3); end
    do_reset();
    checks++; if (wderr3 !== 1'b0) begin errors++; $display("FAIL wd_clear: got %b want 0", wderr3); end
  endtask
`endif

  task automatic test_random();
    int eng_lag, eng_left;
    bit exp_start, exp_run, exp_abort;
    do_reset();
    eng_lag = 0; eng_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      exp_start = m_active && (m_age == 0);
      exp_run   = m_active && (m_drain == 0) && (m_age >= 1);
      exp_abort = WD_EN && exp_run && (m_age == TB_WD) && !((m_age >= 2) && sobel_done);
      checks++; if (busy1 !== m_active) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy1, m_active); end
      checks++; if (start1 !== exp_start) begin errors++; $display("FAIL rnd_start@%0d: got %b want %b", cyc, start1, exp_start); end
      checks++; if (abort1 !== exp_abort || wderr1 !== m_wd_err) begin errors++; $display("FAIL rnd_wd@%0d: got %b/%b want %b/%b", cyc, abort1, wderr1, exp_abort, m_wd_err); end
      checks++; if (pass1 !== 16'(m_pass) || drop1 !== 8'(m_drop)) begin errors++; $display("FAIL rnd_counts@%0d: got %0d/%0d want %0d/%0d", cyc, pass1, drop1, m_pass, m_drop); end
      checks++; if (fb1 !== (m_active ? sobel_rgb_addr : vga_addr) || ewe1 !== (m_active ? sobel_edge_we : 1'b0)) begin
        errors++; $display("FAIL rnd_ports@%0d: got fb=%h we=%b sobel_side=%b", cyc, fb1, ewe1, m_active); end
      // Engine stand-in: keeps done high through the first RUN cycle, then busy for a random time.
      if (eng_left > 0) begin eng_left--; if (eng_left == 0) sobel_done = 1'b1; end
      if (eng_lag > 0) begin eng_lag--; if (eng_lag == 0) begin sobel_done = 1'b0; eng_left = $urandom_range(1, 40); end end
      if (start1) eng_lag = 2;
      frame_valid = ($urandom_range(0, 29) == 0);
      vga_vblank  = ((cyc % 97) < 15);
    end
    frame_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_valid = 1'b0; vga_vblank = 1'b0; sobel_done = 1'b1;
    vga_addr = '0; sobel_rgb_addr = '0; sobel_edge_addr = '0; sobel_edge_din = '0; sobel_edge_we = 1'b0;
    test_reset();
    test_single_pass();
    test_drop();
    test_pass_div3();
    test_drop_saturate();
    test_reset_mid_run();
`ifdef EDGE_SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
